// File: rtl/xor_pkg.sv
// Shared types and constants for the XOR nibble-frame checker.
package xor_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    // A checksum matches when its XOR against the reference is all zeros.
    function automatic logic nib_match(input logic [NIB_W-1:0] a, input logic [NIB_W-1:0] b);
        return ((a ^ b) == {NIB_W{1'b0}});
    endfunction

endpackage

// File: rtl/xor_4b.sv
// Four-bit XOR cell used by the checksum accumulator.
module xor_4b
    import xor_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic [NIB_W-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_frame_checker.sv
// Receive-side checker: accumulates XOR over a nibble frame, compares against the
// trailing checksum nibble, and emits a one-cycle verdict plus saturating counters.
module xor_frame_checker
    import xor_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    output logic             out_ok,
    output logic [3:0]       out_len,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0]       MAX_LEN_C = 4'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [NIB_W-1:0]   acc_r;
    logic [NIB_W-1:0]   xor_s;
    logic [3:0]         len_r;
    logic               ovf_r;
    logic               fire_s;
    logic               verdict_ok_s;
    logic               out_valid_r;
    logic               out_ok_r;
    logic [3:0]         out_len_r;
    logic [CNT_W-1:0]   frame_count_r;
    logic [CNT_W-1:0]   err_count_r;

    xor_4b u_xor (
        .a (acc_r),
        .b (in_data),
        .y (xor_s)
    );

    assign fire_s = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (fire_s) begin
                    state_nxt_s = in_last ? REPORT : ACCUM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (fire_s && in_last) begin
                    state_nxt_s = REPORT;
                end else if (fire_s && (len_r == MAX_LEN_C)) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DRAIN: begin
                if (fire_s && in_last) begin
                    state_nxt_s = REPORT;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            REPORT:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Ready is a function of state only; held low while reset is asserted.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n && (state_r != REPORT)) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Verdict for a checksum nibble arriving in the current state (DRAIN always fails).
    always_comb begin
        verdict_ok_s = 1'b0;
        case (state_r)
            IDLE:    verdict_ok_s = nib_match(in_data, {NIB_W{1'b0}});
            ACCUM:   verdict_ok_s = !ovf_r && nib_match(in_data, acc_r);
            default: verdict_ok_s = 1'b0;
        endcase
    end

    // Accumulator, length and overflow tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 4'd0;
            len_r <= 4'd0;
            ovf_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fire_s && !in_last) begin
                        acc_r <= in_data;
                        len_r <= 4'd1;
                    end
                end
                ACCUM: begin
                    if (fire_s && !in_last) begin
                        if (len_r == MAX_LEN_C) begin
                            ovf_r <= 1'b1;
                        end else begin
                            acc_r <= xor_s;
                            len_r <= len_r + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    acc_r <= acc_r;
                    len_r <= len_r;
                end
                default: begin
                    acc_r <= 4'd0;
                    len_r <= 4'd0;
                    ovf_r <= 1'b0;
                end
            endcase
        end
    end

    // Verdict registers and saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_ok_r      <= 1'b0;
            out_len_r     <= 4'd0;
            frame_count_r <= {CNT_W{1'b0}};
            err_count_r   <= {CNT_W{1'b0}};
        end else begin
            out_valid_r <= fire_s && in_last;
            if (fire_s && in_last) begin
                out_ok_r  <= verdict_ok_s;
                out_len_r <= len_r;
            end
            if (state_r == REPORT) begin
                if (frame_count_r != CNT_MAX_C) begin
                    frame_count_r <= frame_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (!out_ok_r && (err_count_r != CNT_MAX_C)) begin
                    err_count_r <= err_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign out_valid   = out_valid_r;
    assign out_ok      = out_ok_r;
    assign out_len     = out_len_r;
    assign frame_count = frame_count_r;
    assign err_count   = err_count_r;

endmodule
